bsg_nonsynth_mem_req_delay: RTL and testbench

- Fixed-latency, order-preserving delay buffer for manycore request packets.
- Placed between the endpoint's request output (packet_o / packet_v_o / packet_yumi_i) and the zero-latency infinite-memory FSM.
- Gives the testbench memory a configurable, non-zero request latency and finite buffering, so cores see realistic remote-load/store timing and backpressure.
- Non-synthesizable testbench block; opaque to packet contents.

---
 rtl/bsg_nonsynth_mem_req_delay.sv | 103 ++++++++++
 tb/tb_bsg_nonsynth_mem_req_delay.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_mem_req_delay.sv
// Fixed-latency, order-preserving delay buffer for manycore request packets.
// Every accepted packet waits at least latency_p cycles before it is offered to the memory model.
module bsg_nonsynth_mem_req_delay #(
    parameter int width_p        = 32,
    parameter int els_p          = 8,
    parameter int latency_p      = 4,
    parameter int count_width_lp = $clog2(els_p + 1),
    parameter int lat_width_lp   = (latency_p > 1) ? $clog2(latency_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic [width_p-1:0]        data_i,
    input  logic                      v_i,
    output logic                      yumi_o,

    output logic [width_p-1:0]        data_o,
    output logic                      v_o,
    input  logic                      yumi_i,

    output logic [count_width_lp-1:0] count_o
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_lp     = count_width_lp'(els_p);
    localparam logic [lat_width_lp-1:0]   init_cd_lp  = lat_width_lp'(latency_p - 1);

    logic [width_p-1:0]        data_q [els_p];
    logic [width_p-1:0]        data_d [els_p];
    logic [lat_width_lp-1:0]   cd_q   [els_p];
    logic [lat_width_lp-1:0]   cd_d   [els_p];

    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [count_width_lp-1:0] count_q,  count_d;

    logic                      accept;

    // No bypass: a full buffer refuses input even while the head is being consumed.
    assign accept  = v_i & (count_q != full_lp) & ~reset_i;
    assign yumi_o  = accept;

    assign v_o     = (count_q != '0) & (cd_q[rd_ptr_q] == '0);
    assign data_o  = data_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        data_d   = data_q;
        cd_d     = cd_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Free slots also age; harmless since a write reloads the countdown.
        for (int unsigned i = 0; i < els_p; i++) begin
            if (cd_q[i] != '0) begin
                cd_d[i] = cd_q[i] - 1'b1;
            end
        end

        if (accept) begin
            data_d[wr_ptr_q] = data_i;
            cd_d[wr_ptr_q]   = init_cd_lp;
            wr_ptr_d         = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
        end

        if (yumi_i) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({accept, yumi_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        data_q <= data_d;
        cd_q   <= cd_d;
    end

    always_ff @(negedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("bsg_nonsynth_mem_req_delay: yumi_i asserted while v_o is low");
            assert (count_q <= full_lp)
                else $error("bsg_nonsynth_mem_req_delay: occupancy exceeds els_p");
        end
    end

endmodule

// File: tb/tb_bsg_nonsynth_mem_req_delay.sv
// Randomized scoreboard bench for bsg_nonsynth_mem_req_delay (els_p=5, latency_p=4).
// The model is a queue of (packet, accept cycle); the head may leave once latency_p cycles have passed.
module tb_bsg_nonsynth_mem_req_delay;

    localparam int W   = 16;
    localparam int ELS = 5;
    localparam int LAT = 4;
    localparam int CW  = $clog2(ELS + 1);

    typedef struct {
        logic [W-1:0] d;
        int unsigned  t;
    } ent_t;

    logic          clk;
    logic          reset_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          yumi_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          yumi_i;
    logic [CW-1:0] count_o;

    bsg_nonsynth_mem_req_delay #(
        .width_p   (W),
        .els_p     (ELS),
        .latency_p (LAT)
    ) u_dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data_i  (data_i),
        .v_i     (v_i),
        .yumi_o  (yumi_o),
        .data_o  (data_o),
        .v_o     (v_o),
        .yumi_i  (yumi_i),
        .count_o (count_o)
    );

    ent_t         sb[$];
    logic [W-1:0] src_q[$];
    int unsigned  cyc;
    int unsigned  v_pct;
    int unsigned  y_pct;
    bit           rst_req;
    bit           chk_en;
    int           total;
    int           bad;
    bit           ev;
    bit           ey;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit exp_valid();
        return (sb.size() != 0) && (cyc >= sb[0].t + LAT);
    endfunction

    // Driver: inputs change 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        reset_i = rst_req;
        if (rst_req) begin
            v_i    = 1'b0;
            yumi_i = 1'b0;
        end else begin
            v_i    = (src_q.size() != 0) && ($urandom_range(99) < v_pct);
            data_i = (src_q.size() != 0) ? src_q[0] : W'($urandom);
            yumi_i = exp_valid() && ($urandom_range(99) < y_pct);
        end
    end

    // Monitor: compares mid-cycle, then applies this cycle's handshakes to the model.
    always @(negedge clk) begin
        if (chk_en) begin
            ev = exp_valid();
            ey = (v_i === 1'b1) && !reset_i && (sb.size() < ELS);
            chk("yumi_o", 32'(yumi_o), 32'(ey));
            chk("v_o", 32'(v_o), 32'(ev));
            chk("count_o", 32'(count_o), sb.size());
            if (v_o === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL data_o: got %h expected no packet (cycle %0d)", data_o, cyc);
                end else begin
                    chk("data_o", 32'(data_o), 32'(sb[0].d));
                end
            end
            if (reset_i) begin
                sb.delete();
            end else begin
                if (yumi_i && sb.size() != 0) void'(sb.pop_front());
                if (ey) begin
                    sb.push_back('{d: data_i, t: cyc});
                    void'(src_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (src_q.size() == 0 && sb.size() == 0) begin
                idle = 1'b1;
                break;
            end
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL drain: got %0d pending/%0d buffered expected 0/0 within %0d cycles",
                     src_q.size(), sb.size(), budget);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        rst_req = 1'b1;
        chk_en  = 1'b0;
        v_pct   = 100;
        y_pct   = 100;
        total   = 0;
        bad     = 0;
        cyc     = 0;

        repeat (3) @(negedge clk);
        chk_en  = 1'b1;
        rst_req = 1'b0;
        @(negedge clk);
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_v", 32'(v_o), 32'd0);

        // Single packet with the exact latency enforced by the model.
        src_q.push_back(16'h00A5);
        wait_idle(50);

        // Streaming, back to back.
        for (int i = 0; i < 20; i++) src_q.push_back(W'(i));
        wait_idle(100);

        // Full with the consumer stalled; no bypass once the consumer resumes.
        y_pct = 0;
        for (int i = 0; i < 7; i++) src_q.push_back(W'(16'h0100 + i));
        repeat (12) @(negedge clk);
        chk("full_count", 32'(count_o), 32'(ELS));
        chk("full_refuse", 32'(yumi_o), 32'd0);
        y_pct = 100;
        wait_idle(100);

        // Ordering under a long stall.
        y_pct = 0;
        src_q.push_back(16'hAAAA);
        src_q.push_back(16'hBBBB);
        src_q.push_back(16'hCCCC);
        repeat (20) @(negedge clk);
        chk("stall_head_v", 32'(v_o), 32'd1);
        chk("stall_head_data", 32'(data_o), 32'h0000AAAA);
        y_pct = 100;
        wait_idle(100);

        // Random traffic, wraps the non-power-of-two pointers many times.
        v_pct = 70;
        y_pct = 60;
        for (int i = 0; i < 60; i++) src_q.push_back(W'($urandom));
        wait_idle(2000);

        // Reset with three packets buffered, two of them already aged.
        v_pct = 100;
        y_pct = 0;
        for (int i = 0; i < 3; i++) src_q.push_back(W'(16'h0D00 + i));
        repeat (6) @(negedge clk);
        rst_req = 1'b1;
        @(negedge clk);
        rst_req = 1'b0;
        @(negedge clk);
        chk("post_reset_count", 32'(count_o), 32'd0);
        chk("post_reset_v", 32'(v_o), 32'd0);
        y_pct = 100;
        src_q.push_back(16'h1234);
        wait_idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
